// File: rtl/uart_tx.sv
// UART transmitter with a small byte FIFO: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
// Bytes enter through a valid/ready handshake and leave LSB-first on a flop-driven tx line.
module uart_tx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [7:0]           shift, shift_next;
  logic [2:0]           idx, idx_next;
  logic                 tx_next;
  logic                 pop, push, bit_end;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [7:0]           head;
`ifdef UART_TX_PARITY_EN
  logic                 parity, parity_next;
`endif

  // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready depends only on the registered count, so a full FIFO never accepts.
  assign tx_ready = (fifo_count < DEPTH_C);
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr];
  assign bit_end  = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + (PTR_W + 1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (PTR_W + 1)'(1);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift;
    idx_next   = idx;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop        = 1'b1;
          shift_next = head;
          cnt_next   = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          parity_next = ^head;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = 3'd0;
          state_next = DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = {1'b0, shift[7:1]};
          idx_next   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx == 3'd7) state_next = PARITY;
`else
          if (idx == 3'd7) state_next = STOP;
`endif
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = STOP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          // A waiting byte starts its frame on the very next cycle, no idle gap.
          if (fifo_count != '0) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head;
`endif
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shift <= shift_next;
      idx   <= idx_next;
      tx    <= tx_next;
      busy  <= (state_next != IDLE);
`ifdef UART_TX_PARITY_EN
      parity <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line monitor decodes frames, and a timing/order model
// predicts each byte's start-bit cycle from its accept cycle.
module tb_uart_tx;

  localparam int CLK_HZ = 100000;
  localparam int BAUD   = 10000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;
  localparam int TMO   = 40 * FRAME;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, tx, busy;
  logic [$clog2(DEPTH):0] fifo_count;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  int         exp_fall_q[$];
  int         last_fall = -1000000;
  logic [7:0] mon_data_q[$];
  int         mon_fall_q[$];
  logic       mon_ok_q[$];
  logic       mon_par_q[$];

  uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  // Clock / cycle counter: after edge k settles, cyc == k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: decodes each frame by sampling bit centres.
  initial begin
    logic [7:0] d;
    logic ok, p;
    int f;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        f = cyc;
        p = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        ok = ok && (tx === 1'b1);
        mon_data_q.push_back(d);
        mon_fall_q.push_back(f);
        mon_ok_q.push_back(ok);
        mon_par_q.push_back(p);
      end
    end
  end

  // Driver: holds tx_valid with b until accepted; records the model expectation.
  task automatic push(input logic [7:0] b, output int acc);
    int waited;
    int ef;
    logic r;
    tx_valid = 1'b1;
    tx_data  = b;
    waited   = 0;
    acc      = -1;
    while (acc < 0 && waited < TMO) begin
      r = tx_ready;
      @(posedge clk);
      #1;
      if (r) acc = cyc;
      waited++;
    end
    if (acc < 0) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: byte %02h not accepted in %0d cycles", b, TMO);
    end else begin
      ef = acc + 1;
      if (last_fall + FRAME > ef) ef = last_fall + FRAME;
      last_fall = ef;
      exp_q.push_back(b);
      exp_fall_q.push_back(ef);
    end
  endtask

  task automatic wait_frames(input int n);
    int waited = 0;
    while (mon_data_q.size() < n && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    if (mon_data_q.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: got %0d frames want %0d", mon_data_q.size(), n);
    end
  endtask

  task automatic settle();
    int waited = 0;
    while ((busy !== 1'b0 || fifo_count !== '0) && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    repeat (2 * CPB) @(negedge clk);
    mon_data_q.delete(); mon_fall_q.delete(); mon_ok_q.delete(); mon_par_q.delete();
    exp_q.delete(); exp_fall_q.delete();
    last_fall = -1000000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: tx %b busy %b want 1 0", tx, busy); end
  endtask

  task automatic test_single();
    int acc, fall, bfall, waited;
    logic [7:0] e;
    @(negedge clk);
    push(8'h54, acc);
    tx_valid = 1'b0;
    wait_frames(1);
    e = exp_q.pop_front();
    fall = exp_fall_q.pop_front();
    vectors++; if (mon_data_q[0] !== e) begin miscompares++; $display("FAIL single_data: got %02h want %02h", mon_data_q[0], e); end
    vectors++; if (mon_fall_q[0] !== acc + 1) begin miscompares++; $display("FAIL single_fall: got %0d want %0d", mon_fall_q[0], acc + 1); end
    vectors++; if (mon_ok_q[0] !== 1'b1) begin miscompares++; $display("FAIL single_framing: got %b want 1", mon_ok_q[0]); end
`ifdef UART_TX_PARITY_EN
    vectors++; if (mon_par_q[0] !== ^e) begin miscompares++; $display("FAIL single_parity: got %b want %b", mon_par_q[0], ^e); end
`endif
    waited = 0;
    while (busy !== 1'b0 && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    bfall = cyc;
    vectors++; if (bfall !== fall + FRAME) begin miscompares++; $display("FAIL single_busy_fall: got %0d want %0d", bfall, fall + FRAME); end
    settle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    int acc [4];
    int ef;
    logic [7:0] e;
    bytes[0] = 8'h53; bytes[1] = 8'h51; bytes[2] = 8'h57; bytes[3] = 8'h4E;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(bytes[i], acc[i]);
    tx_valid = 1'b0;
    vectors++; if (acc[3] !== acc[0] + 3) begin miscompares++; $display("FAIL b2b_ready: last accept %0d want %0d", acc[3], acc[0] + 3); end
    wait_frames(4);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      ef = exp_fall_q.pop_front();
      vectors++; if (mon_data_q[i] !== e || mon_ok_q[i] !== 1'b1) begin miscompares++; $display("FAIL b2b_data%0d: got %02h ok %b want %02h ok 1", i, mon_data_q[i], mon_ok_q[i], e); end
      vectors++; if (mon_fall_q[i] !== ef) begin miscompares++; $display("FAIL b2b_fall%0d: got %0d want %0d", i, mon_fall_q[i], ef); end
    end
    vectors++; if (mon_fall_q[3] - mon_fall_q[0] !== 3 * FRAME) begin miscompares++; $display("FAIL b2b_span: got %0d want %0d", mon_fall_q[3] - mon_fall_q[0], 3 * FRAME); end
    settle();
  endtask

  task automatic test_overflow();
    logic [7:0] base;
    int acc [6];
    int ef;
    logic [7:0] e;
    base = 8'($urandom_range(0, 255));
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(base + 8'(i * 37), acc[i]);
    vectors++; if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_full: count %0d ready %b want 4 0", fifo_count, tx_ready); end
    vectors++; if (acc[4] !== acc[0] + 4) begin miscompares++; $display("FAIL ovf_accepts: fifth at %0d want %0d", acc[4], acc[0] + 4); end
    push(base + 8'(5 * 37), acc[5]);
    tx_valid = 1'b0;
    vectors++; if (acc[5] !== acc[0] + 1 + FRAME + 1) begin miscompares++; $display("FAIL ovf_sixth_accept: got %0d want %0d", acc[5], acc[0] + FRAME + 2); end
    wait_frames(6);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      ef = exp_fall_q.pop_front();
      vectors++; if (mon_data_q[i] !== e || mon_ok_q[i] !== 1'b1 || mon_fall_q[i] !== ef) begin
        miscompares++; $display("FAIL ovf_frame%0d: got %02h ok %b at %0d want %02h ok 1 at %0d", i, mon_data_q[i], mon_ok_q[i], mon_fall_q[i], e, ef);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_frame();
    int acc, target, waited, bad;
    logic [7:0] a;
    logic [7:0] e;
    a = 8'h41;
    @(negedge clk);
    push(a, acc);
    push(8'h42, acc);
    tx_valid = 1'b0;
    target = exp_fall_q[0] + 4 * CPB + CPB / 2;
    waited = 0;
    while (cyc < target && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    vectors++; if (tx !== a[3]) begin miscompares++; $display("FAIL mid_bit3: got %b want %b", tx, a[3]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) begin
      miscompares++; $display("FAIL mid_reset: tx %b busy %b count %0d want 1 0 0", tx, busy, fifo_count);
    end
    exp_q.delete(); exp_fall_q.delete();
    last_fall = -1000000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL mid_residual: %0d non-idle cycles want 0", bad); end
    settle();
    push(8'h46, acc);
    tx_valid = 1'b0;
    wait_frames(1);
    e = exp_q.pop_front();
    vectors++; if (mon_data_q[0] !== e || mon_ok_q[0] !== 1'b1 || mon_fall_q[0] !== exp_fall_q[0]) begin
      miscompares++; $display("FAIL mid_resend: got %02h ok %b at %0d want %02h ok 1 at %0d", mon_data_q[0], mon_ok_q[0], mon_fall_q[0], e, exp_fall_q[0]);
    end
    settle();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int acc;
    @(negedge clk);
    push(8'h54, acc);
    push(8'h55, acc);
    tx_valid = 1'b0;
    wait_frames(2);
    vectors++; if (mon_par_q[0] !== 1'b1 || mon_par_q[1] !== 1'b0) begin miscompares++; $display("FAIL parity_bits: got %b %b want 1 0", mon_par_q[0], mon_par_q[1]); end
    vectors++; if (mon_fall_q[1] - mon_fall_q[0] !== 11 * CPB) begin miscompares++; $display("FAIL parity_len: got %0d want %0d", mon_fall_q[1] - mon_fall_q[0], 11 * CPB); end
    settle();
  endtask
`endif

  task automatic test_random();
    localparam int N = 16;
    int acc, ef, gap;
    logic [7:0] e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      push(8'($urandom_range(0, 255)), acc);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, FRAME + 20);
      if (gap > 0) begin
        tx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    tx_valid = 1'b0;
    wait_frames(N);
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front();
      ef = exp_fall_q.pop_front();
      vectors++; if (mon_data_q[i] !== e || mon_ok_q[i] !== 1'b1 || mon_fall_q[i] !== ef) begin
        miscompares++; $display("FAIL rand_frame%0d: got %02h ok %b at %0d want %02h ok 1 at %0d", i, mon_data_q[i], mon_ok_q[i], mon_fall_q[i], e, ef);
      end
`ifdef UART_TX_PARITY_EN
      vectors++; if (mon_par_q[i] !== ^e) begin miscompares++; $display("FAIL rand_parity%0d: got %b want %b", i, mon_par_q[i], ^e); end
`endif
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
